// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit.
// Accepts one op per cycle from execute. Non-memory ops pass straight to
// writeback. Aligned, legal loads and stores run one request/acknowledge
// access on the data-memory port, while execute is stalled.
// Lane alignment and load extension are handled here.
// Every writeback field is registered.

module mem_stage_lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_misaligned,
  output logic        wb_fault
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [31:0] LP_MAX_WAIT = 32'(MAX_WAIT);
  localparam logic [31:0] LP_TO_LAST  = LP_MAX_WAIT - 32'd1;

  // Byte enables for a given width and low address bits.
  function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane the width can land in.
  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Lane select plus sign/zero extension of a read word.
  function automatic logic [31:0] f_load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Width encodings that have no meaning for the op kind.
  function automatic logic f_illegal(input logic is_load, input logic is_store,
                                     input logic [2:0] f3);
    logic ill;
    if (is_load) begin
      ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end else if (is_store) begin
      ill = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
    end else begin
      ill = 1'b0;
    end
    return ill;
  endfunction

  // Halves need an even address, words need a 4-byte aligned address.
  function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = lo[0];
      2'b10:   mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic        w_capture;

  logic [31:0] r_addr;
  logic [1:0]  r_lo;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;

  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_wb_mis;
  logic        r_wb_fault;
  logic        w_wb_valid;
  logic [4:0]  w_wb_rd;
  logic [31:0] w_wb_data;
  logic        w_wb_mis;
  logic        w_wb_fault;

  logic w_in_access;
  logic w_accept;
  logic w_is_mem;
  logic w_illegal;
  logic w_misal;
  logic w_timeout;

  assign w_in_access = (r_state == ST_ACCESS);
  assign w_accept    = ex_valid & (r_state == ST_IDLE);
  assign w_is_mem    = ex_is_load | ex_is_store;
  assign w_illegal   = f_illegal(ex_is_load, ex_is_store, ex_funct3);
  assign w_misal     = f_misaligned(ex_funct3, ex_alu_result[1:0]);
  assign w_timeout   = (LP_MAX_WAIT != 32'd0) && (r_cnt == LP_TO_LAST);

  assign ex_ready   = (r_state == ST_IDLE);
  assign dmem_req   = w_in_access;
  assign dmem_we    = w_in_access & r_we;
  assign dmem_addr  = w_in_access ? r_addr  : 32'd0;
  assign dmem_be    = w_in_access ? r_be    : 4'd0;
  assign dmem_wdata = w_in_access ? r_wdata : 32'd0;

  assign wb_valid      = r_wb_valid;
  assign wb_rd         = r_wb_rd;
  assign wb_data       = r_wb_data;
  assign wb_misaligned = r_wb_mis;
  assign wb_fault      = r_wb_fault;

  // Next state, wait counter, capture strobe and the next writeback beat.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_wb_valid  = 1'b0;
    w_wb_rd     = 5'd0;
    w_wb_data   = 32'd0;
    w_wb_mis    = 1'b0;
    w_wb_fault  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_accept) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_is_mem) begin
          w_wb_valid = 1'b1;
          w_wb_rd    = ex_rd;
          w_wb_data  = ex_alu_result;
        end else if (w_illegal) begin
          w_wb_valid = 1'b1;
          w_wb_fault = 1'b1;
        end else if (w_misal) begin
          w_wb_valid = 1'b1;
          w_wb_mis   = 1'b1;
        end else begin
          w_capture   = 1'b1;
          w_cnt_nxt   = 32'd0;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (dmem_err) begin
          // An error beats a simultaneous ack.
          w_state_nxt = ST_IDLE;
          w_wb_valid  = 1'b1;
          w_wb_fault  = 1'b1;
        end else if (dmem_ack) begin
          w_state_nxt = ST_IDLE;
          w_wb_valid  = 1'b1;
          w_wb_rd     = r_we ? 5'd0  : r_rd;
          w_wb_data   = r_we ? 32'd0 : f_load_ext(r_funct3, r_lo, dmem_rdata);
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_wb_valid  = 1'b1;
          w_wb_fault  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and access wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Hold the accepted memory op steady for the whole access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr   <= 32'd0;
      r_lo     <= 2'd0;
      r_funct3 <= 3'd0;
      r_we     <= 1'b0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
      r_rd     <= 5'd0;
    end else if (w_capture) begin
      r_addr   <= {ex_alu_result[31:2], 2'b00};
      r_lo     <= ex_alu_result[1:0];
      r_funct3 <= ex_funct3;
      r_we     <= ex_is_store;
      r_be     <= f_be(ex_funct3, ex_alu_result[1:0]);
      r_wdata  <= ex_is_store ? f_wdata(ex_funct3, ex_store_data) : 32'd0;
      r_rd     <= ex_rd;
    end else begin
      r_addr   <= r_addr;
      r_lo     <= r_lo;
      r_funct3 <= r_funct3;
      r_we     <= r_we;
      r_be     <= r_be;
      r_wdata  <= r_wdata;
      r_rd     <= r_rd;
    end
  end

  // Registered writeback beat; the fields are zero when no beat is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
      r_wb_mis   <= 1'b0;
      r_wb_fault <= 1'b0;
    end else begin
      r_wb_valid <= w_wb_valid;
      r_wb_rd    <= w_wb_rd;
      r_wb_data  <= w_wb_data;
      r_wb_mis   <= w_wb_mis;
      r_wb_fault <= w_wb_fault;
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit forming the memory stage directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address (or as a pass-through result for non-memory ops).
- Drives a single-outstanding request/acknowledge data-memory port, performs byte-lane alignment and load sign/zero extension.
- Presents a registered writeback beat.
- Back-pressures execute through ex_ready while an access is in flight.

Parameters:
MAX_WAIT, 255, cycles to wait for dmem_ack/dmem_err before declaring a fault; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute stage presents an op
ex_ready  out  1  LSU accepts an op this cycle (high only in IDLE)
ex_is_load  in  1  op is a load
ex_is_store  in  1  op is a store (never together with ex_is_load)
ex_funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ex_alu_result  in  32  effective address, or result for non-memory ops
ex_store_data  in  32  rs2 value for stores
ex_rd  in  5  destination register
dmem_req  out  1  request, held stable until ack/err/timeout
dmem_we  out  1  1 = write
dmem_addr  out  32  word address (bits [1:0] = 00)
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  access complete; dmem_rdata valid this cycle
dmem_rdata  in  32  read word
dmem_err  in  1  bus error, terminates the access
wb_valid  out  1  one-cycle writeback pulse
wb_rd  out  5  destination; 0 for stores and faults
wb_data  out  32  load data or pass-through result
wb_misaligned  out  1  address misaligned for width (valid with wb_valid)
wb_fault  out  1  bus error, timeout or illegal funct3 (valid with wb_valid)

Behaviour:
- Reset (async, reset_n=0):
  - State is IDLE, timeout counter is 0.
  - All outputs are 0 except ex_ready=1.
  - Reset mid-access drops dmem_req immediately; any later ack for that access is ignored.
- FSM has states IDLE and ACCESS. Acceptance = ex_valid & ex_ready at a rising edge.
- Non-memory op (neither load nor store):
  - Next cycle: wb_valid=1, wb_data=ex_alu_result, wb_rd=ex_rd.
  - State stays IDLE. Throughput is 1 per cycle.
- Misalignment: H or HU with addr[0]=1, or W with addr[1:0]≠00.
  - Response: no bus access; next cycle wb_valid=1, wb_misaligned=1, wb_data=0, wb_rd=0.
- Illegal funct3: loads with 011/110/111; stores with anything other than 000/001/010.
  - Response: same as misalignment, but with wb_fault=1 instead of wb_misaligned.
- Aligned legal memory op:
  - Op is captured; state moves to ACCESS; ex_ready=0.
  - In ACCESS, dmem_req=1 with dmem_addr={addr[31:2],00} and dmem_we=is_store; dmem_be/dmem_wdata are held constant.
  - Byte access at lane k: be=1<<k, wdata={4{data[7:0]}}.
  - Half access: be=0011 (addr[1]=0) or 1100 (addr[1]=1), wdata={2{data[15:0]}}.
  - Word access: be=1111, wdata=data.
  - For loads, be uses the same encoding as stores; wdata=0.
- Termination:
  - First cycle with dmem_ack or dmem_err: drop dmem_req and return to IDLE.
  - Next cycle wb_valid=1.
  - Ack may arrive in the first ACCESS cycle, so the minimum accept-to-wb_valid latency is 2 cycles.
- Load result:
  - Select the byte or half lane from the addr[1:0] captured at acceptance.
  - B and H sign-extend; BU and HU zero-extend; W passes the word through.
  - wb_rd=ex_rd.
- Store result: wb_rd=0, wb_data=0.
- Error handling:
  - dmem_err, or dmem_err together with dmem_ack: wb_fault=1, wb_data=0, wb_rd=0. Error wins over ack.
  - Timeout (MAX_WAIT>0): the counter increments each ACCESS cycle without ack/err.
  - When the counter reaches MAX_WAIT, drop req and issue a wb_valid beat with wb_fault=1.
  - The counter clears on entering ACCESS.
- ex_ready returns high in the same cycle wb_valid pulses, so back-to-back ops are allowed.
- All wb_* outputs are registered. wb_misaligned, wb_fault and wb_data are 0 whenever wb_valid=0.

Test Plan:
- Non-memory op with ex_alu_result=0x0000_1234, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5; no dmem_req.
- SB at 0x103, data 0x0000_00A5 -> dmem_addr=0x100, be=1000, wdata=0xA5A5_A5A5, we=1; ack after 3 cycles -> wb_valid one cycle later with wb_rd=0; ex_ready low throughout ACCESS.
- LB at 0x202 with rdata 0x0080_0000 and ack in first cycle -> wb_data=0xFFFF_FF80 two cycles after accept. LBU at the same address -> 0x0000_0080. LH at 0x202 with rdata 0x8001_0000 -> 0xFFFF_8001.
- LW at 0x201 -> no dmem_req, next cycle wb_misaligned=1, wb_rd=0. Load with funct3=011 -> wb_fault=1.
- LW with dmem_err and dmem_ack asserted together -> wb_fault=1, wb_data=0. With MAX_WAIT=4 and no ack -> req drops after 4 ACCESS cycles, wb_fault=1.
- Deassert reset_n during ACCESS -> dmem_req=0 immediately. Ack one cycle after reset release -> no wb_valid; ex_ready=1.
